// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle LEGv8 sequencer: one instruction phase per clock, variable-latency memory via mem_ready,
// with timeout and illegal-opcode traps, sticky error flags and a retired-instruction counter.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pcWrite,
  output logic [1:0]  pcSrcSel,
  output logic        irWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        memtoReg,
  output logic        regWrite,
  output logic        reg2Loc,
  output logic        ALUSrc,
  output logic [2:0]  ALUOp,
  output logic [1:0]  err,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_LDUR = 3'd1,
    C_STUR = 3'd2,
    C_CBZ  = 3'd3,
    C_CBNZ = 3'd4,
    C_B    = 3'd5,
    C_ILL  = 3'd6
  } class_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  class_t            r_class;
  logic [TMO_W-1:0]  r_wait;
  logic [1:0]        r_err;
  logic [31:0]       r_instret;

  class_t            w_class;
  class_t            w_cur_class;
  state_t            w_after_retire;

  always_comb begin
    w_class = C_ILL;
    if (opcode == 11'b10001011000 || opcode == 11'b11001011000 ||
        opcode == 11'b10001010000 || opcode == 11'b10101010000)
      w_class = C_R;
    else if (opcode == 11'b11111000010)
      w_class = C_LDUR;
    else if (opcode == 11'b11111000000)
      w_class = C_STUR;
    else if (opcode[10:3] == 8'b10110100)
      w_class = C_CBZ;
    else if (opcode[10:3] == 8'b10110101)
      w_class = C_CBNZ;
    else if (opcode[10:5] == 6'b000101)
      w_class = C_B;
  end

  // The class is only latched at the end of DECODE, so DECODE itself uses the live decode.
  assign w_cur_class    = (r_state == S_DECODE) ? w_class : r_class;
  assign w_after_retire = halt_req ? S_IDLE : S_FETCH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_class   <= C_R;
      r_wait    <= '0;
      r_err     <= 2'b00;
      r_instret <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_wait <= '0;
          if (!halt_req) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            r_wait  <= '0;
            r_state <= S_DECODE;
          end else if (r_wait == TMO_LAST) begin
            r_err[1] <= 1'b1;
            r_state  <= S_TRAP;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_DECODE: begin
          r_wait  <= '0;
          r_class <= w_class;
          if (w_class == C_ILL) begin
            r_err[0] <= 1'b1;
            r_state  <= S_TRAP;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_wait <= '0;
          unique case (r_class)
            C_R:           r_state <= S_WB;
            C_LDUR, C_STUR: r_state <= S_MEM;
            C_CBZ, C_CBNZ, C_B: begin
              r_instret <= r_instret + 32'd1;
              r_state   <= w_after_retire;
            end
            default:       r_state <= S_TRAP;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            r_wait <= '0;
            if (r_class == C_STUR) begin
              r_instret <= r_instret + 32'd1;
              r_state   <= w_after_retire;
            end else begin
              r_state <= S_WB;
            end
          end else if (r_wait == TMO_LAST) begin
            r_err[1] <= 1'b1;
            r_state  <= S_TRAP;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WB: begin
          r_wait    <= '0;
          r_instret <= r_instret + 32'd1;
          r_state   <= w_after_retire;
        end
        default: begin
          r_wait  <= '0;
          r_state <= S_TRAP;
        end
      endcase
    end
  end

  // Strobes decode directly from the state register so an async reset drops them at once.
  always_comb begin
    pcWrite  = 1'b0;
    pcSrcSel = 2'b00;
    irWrite  = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    memtoReg = 1'b0;
    regWrite = 1'b0;
    reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 3'b000;
    if (r_state == S_DECODE || r_state == S_EXEC || r_state == S_MEM || r_state == S_WB)
      reg2Loc = (w_cur_class == C_STUR) || (w_cur_class == C_CBZ) || (w_cur_class == C_CBNZ);
    unique case (r_state)
      S_FETCH: begin
        memRead = 1'b1;
        irWrite = mem_ready;
        pcWrite = mem_ready;
      end
      S_EXEC: begin
        unique case (r_class)
          C_R:            ALUOp = 3'b010;
          C_LDUR, C_STUR: ALUSrc = 1'b1;
          C_CBZ: begin
            ALUOp    = 3'b001;
            pcSrcSel = 2'b01;
            pcWrite  = zero;
          end
          C_CBNZ: begin
            ALUOp    = 3'b001;
            pcSrcSel = 2'b01;
            pcWrite  = ~zero;
          end
          C_B: begin
            pcSrcSel = 2'b10;
            pcWrite  = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        memRead  = (r_class == C_LDUR);
        memWrite = (r_class == C_STUR);
      end
      S_WB: begin
        regWrite = 1'b1;
        memtoReg = (r_class == C_LDUR);
      end
      default: ;
    endcase
  end

  assign err     = r_err;
  assign state   = r_state;
  assign instret = r_instret;

endmodule
